mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single external memory bus between the instruction-fetch port (read-only) and the MEM-stage data port (read/write, byte-selected).
- Sequences each transaction with a req/ack handshake against the bus. Returns read data and a one-cycle done pulse to the winning requester.
- Raises a stall request to the pipeline controller while any access is outstanding. A bus that never acknowledges is aborted by a timeout.

Parameters:
- TIMEOUT_CYCLES, 255: bus cycles to wait for bus_ack_i before aborting. 0 disables the timeout.
- CNT_W, 8: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- if_req_i  in  1  fetch request (level; held until if_done_o)
- if_addr_i  in  32  fetch address
- if_done_o  out  1  one-cycle fetch completion pulse
- if_rdata_o  out  32  fetched word, valid with if_done_o
- mem_req_i  in  1  data request (level; held until mem_done_o)
- mem_we_i  in  1  1 = write, 0 = read
- mem_sel_i  in  4  byte enables
- mem_addr_i  in  32  data address
- mem_wdata_i  in  32  write data
- mem_done_o  out  1  one-cycle data completion pulse
- mem_rdata_o  out  32  read data, valid with mem_done_o
- bus_req_o  out  1  bus transaction request
- bus_we_o  out  1  bus write enable
- bus_sel_o  out  4  bus byte enables
- bus_addr_o  out  32  bus address
- bus_wdata_o  out  32  bus write data
- bus_ack_i  in  1  bus completion (may arrive in the first cycle bus_req_o is high)
- bus_rdata_i  in  32  bus read data, valid with bus_ack_i
- bus_err_o  out  1  one-cycle pulse on timeout abort
- stallreq_o  out  1  pipeline stall request

Behaviour:
- Reset, sampled on the clk edge: state IDLE, counter 0. All outputs 0: bus_*, *_done_o, *_rdata_o, bus_err_o.
- Reset mid-transaction: bus_req_o is 0 after the edge, no done pulse is generated, and the latched request is discarded.
- States and transitions:
  - IDLE: if mem_req_i, latch mem_we/sel/addr/wdata and go to DATA. Else if if_req_i, latch if_addr (we=0, sel=4'b1111) and go to INST. Otherwise stay.
  - Data has fixed priority over fetch when both are high in the same cycle.
  - DATA / INST: bus_req_o = 1 and the bus_* fields come from the latched registers, constant for the whole transaction.
  - On bus_ack_i in DATA/INST: pulse done next cycle and go to RECOVER.
  - On a read ack, capture bus_rdata_i into the owner's rdata_o. On a write, mem_rdata_o keeps its previous value.
  - RECOVER (exactly 1 cycle): requests are ignored, so the requester can drop its req after seeing done. Then go to IDLE.
- Registered outputs: bus_req_o, bus_*, done, rdata and bus_err_o are all registered. bus_req_o is 1 exactly while the state is DATA or INST.
- Minimum latency: req at cycle 0 → bus_req_o at 1 → ack at 1 → done at 2 → IDLE at 3. Next grant at the earliest at 3, bus_req_o at 4.
- Timeout:
  - The counter clears on entry to DATA/INST and increments each cycle without ack.
  - When it equals TIMEOUT_CYCLES (nonzero), drop bus_req_o. Next cycle, pulse the owner's done with rdata_o = 0 and pulse bus_err_o, then go to RECOVER.
  - If ack arrives in the same cycle the timeout is reached, ack wins: normal completion, no bus_err_o.
- bus_ack_i outside DATA/INST is ignored.
- stallreq_o = (mem_req_i & ~mem_done_o) | (if_req_i & ~if_done_o). This is combinational from the inputs and the registered done flags.
- Fetch starvation is excluded by the pipeline: a stalled MEM stage issues one data request per instruction, so fetch wins the next free IDLE.

Decomposition:
- consts.vh gains the state encodings ArbIdle, ArbInst, ArbData, ArbRecover (2-bit), plus ByteSelAll = 4'b1111 and BusAddrBus/BusSelBus.
- Address and data widths reuse the existing bus macros (RegDataBus, ZeroWord).
- One natural sub-module: bus_timer, the clear/increment/compare timeout counter with expired_o.

Test Plan:
- Fetch only: if_req_i=1, if_addr_i=0x0000_0040, bus acks at 2nd bus cycle with 0x2402_0005 → bus_addr_o=0x40, bus_we_o=0; if_done_o pulses once with if_rdata_o=0x2402_0005; stallreq_o=1 until the done cycle.
- Simultaneous requests: if_req and mem_req (read, 0x1000_0000) high in the same cycle, zero-wait ack → data served first (mem_done_o at cycle 2); fetch bus_req_o at cycle 4; if_done_o at cycle 5.
- Data write: mem_we_i=1, sel=4'b0011, wdata=0xDEAD_BEEF → bus_we_o=1, bus_sel_o=4'b0011, bus_wdata_o=0xDEAD_BEEF stable until ack; mem_rdata_o unchanged; single mem_done_o.
- Timeout: TIMEOUT_CYCLES=4, bus_ack_i never asserted → bus_req_o high for 5 cycles then low; mem_done_o, bus_err_o and mem_rdata_o=0 one cycle later. Repeat with ack on the 5th bus cycle → normal completion, no bus_err_o.
- Reset mid-transaction: assert rst during DATA with bus not acking → bus_req_o=0 next cycle, no done pulse; after release, a fresh if_req_i is granted normally.
- Spurious ack: bus_ack_i=1 in IDLE and RECOVER → no done pulses, no state change.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory bus arbiter.
package mem_bus_arbiter_pkg;

    localparam int unsigned RegDataW = 32'd32;
    localparam int unsigned BusAddrW = 32'd32;
    localparam int unsigned BusSelW  = 32'd4;

    localparam logic [RegDataW-1:0] ZeroWord   = 32'h0000_0000;
    localparam logic [BusSelW-1:0]  ByteSelAll = 4'b1111;

    // Arbiter states; INST and DATA are the only states that drive the bus.
    typedef enum logic [1:0] {
        ArbIdle    = 2'b00,
        ArbInst    = 2'b01,
        ArbData    = 2'b10,
        ArbRecover = 2'b11
    } arb_state_e;

    // One latched bus transaction, held constant while it is on the bus.
    typedef struct packed {
        logic                we;
        logic [BusSelW-1:0]  sel;
        logic [BusAddrW-1:0] addr;
        logic [RegDataW-1:0] wdata;
    } bus_txn_t;

    // True while the given state owns the external bus.
    function automatic logic arb_on_bus(input arb_state_e state);
        return (state == ArbInst) || (state == ArbData);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_timer.sv
// Bus timeout counter: cleared while the bus is idle, counts unacknowledged
// bus cycles, and flags expiry when the count reaches the limit.
module bus_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd255,
    parameter int unsigned CNT_W          = 32'd8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] Limit  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(32'd1);

    logic [CNT_W-1:0] cnt_r;

    // Count cycles spent on the bus without an acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clear_i) begin
            cnt_r <= '0;
        end else if (inc_i) begin
            cnt_r <= cnt_r + CntOne;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // A limit of zero disables the timeout entirely.
    assign expired_o = (TIMEOUT_CYCLES != 32'd0) && (cnt_r == Limit);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single external memory bus between instruction fetch and
// MEM-stage data accesses. Data has fixed priority; each transaction runs a
// req/ack handshake, ends with a one-cycle done pulse to its owner, and is
// followed by one recovery cycle so the owner can drop its request.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 32'd255,
    parameter int unsigned CNT_W          = 32'd8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_i,
    input  logic [BusAddrW-1:0] if_addr_i,
    output logic                if_done_o,
    output logic [RegDataW-1:0] if_rdata_o,
    input  logic                mem_req_i,
    input  logic                mem_we_i,
    input  logic [BusSelW-1:0]  mem_sel_i,
    input  logic [BusAddrW-1:0] mem_addr_i,
    input  logic [RegDataW-1:0] mem_wdata_i,
    output logic                mem_done_o,
    output logic [RegDataW-1:0] mem_rdata_o,
    output logic                bus_req_o,
    output logic                bus_we_o,
    output logic [BusSelW-1:0]  bus_sel_o,
    output logic [BusAddrW-1:0] bus_addr_o,
    output logic [RegDataW-1:0] bus_wdata_o,
    input  logic                bus_ack_i,
    input  logic [RegDataW-1:0] bus_rdata_i,
    output logic                bus_err_o,
    output logic                stallreq_o
);

    arb_state_e          state_r, state_s;
    bus_txn_t            txn_r, txn_s;
    logic                bus_req_r, bus_req_s;
    logic                if_done_r, if_done_s;
    logic                mem_done_r, mem_done_s;
    logic                bus_err_r, bus_err_s;
    logic [RegDataW-1:0] if_rdata_r, if_rdata_s;
    logic [RegDataW-1:0] mem_rdata_r, mem_rdata_s;
    logic                on_bus_s;
    logic                expired_s;

    assign on_bus_s = arb_on_bus(state_r);

    bus_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_bus_timer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (~on_bus_s),
        .inc_i    (on_bus_s & ~bus_ack_i),
        .expired_o(expired_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ArbIdle;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state: grant data before fetch, finish on ack or timeout.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ArbIdle: begin
                if (mem_req_i) begin
                    state_s = ArbData;
                end else if (if_req_i) begin
                    state_s = ArbInst;
                end else begin
                    state_s = ArbIdle;
                end
            end
            ArbInst, ArbData: begin
                if (bus_ack_i || expired_s) begin
                    state_s = ArbRecover;
                end else begin
                    state_s = state_r;
                end
            end
            ArbRecover: state_s = ArbIdle;
            default:    state_s = ArbIdle;
        endcase
    end

    // Output decode: next values of the latched transaction, done pulses,
    // read data and error flag. An ack in the expiry cycle counts as success.
    always_comb begin
        txn_s       = txn_r;
        if_done_s   = 1'b0;
        mem_done_s  = 1'b0;
        bus_err_s   = 1'b0;
        if_rdata_s  = if_rdata_r;
        mem_rdata_s = mem_rdata_r;
        bus_req_s   = arb_on_bus(state_s);
        case (state_r)
            ArbIdle: begin
                if (mem_req_i) begin
                    txn_s = '{we: mem_we_i, sel: mem_sel_i, addr: mem_addr_i, wdata: mem_wdata_i};
                end else if (if_req_i) begin
                    txn_s = '{we: 1'b0, sel: ByteSelAll, addr: if_addr_i, wdata: ZeroWord};
                end else begin
                    txn_s = txn_r;
                end
            end
            ArbInst: begin
                if (bus_ack_i) begin
                    if_done_s  = 1'b1;
                    if_rdata_s = bus_rdata_i;
                end else if (expired_s) begin
                    if_done_s  = 1'b1;
                    if_rdata_s = ZeroWord;
                    bus_err_s  = 1'b1;
                end else begin
                    if_done_s  = 1'b0;
                end
            end
            ArbData: begin
                if (bus_ack_i) begin
                    mem_done_s = 1'b1;
                    if (!txn_r.we) begin
                        mem_rdata_s = bus_rdata_i;
                    end else begin
                        mem_rdata_s = mem_rdata_r;
                    end
                end else if (expired_s) begin
                    mem_done_s  = 1'b1;
                    mem_rdata_s = ZeroWord;
                    bus_err_s   = 1'b1;
                end else begin
                    mem_done_s  = 1'b0;
                end
            end
            ArbRecover: begin
                txn_s = txn_r;
            end
            default: begin
                txn_s = txn_r;
            end
        endcase
    end

    // Output registers; reset discards any latched transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            txn_r       <= '{we: 1'b0, sel: 4'b0000, addr: ZeroWord, wdata: ZeroWord};
            bus_req_r   <= 1'b0;
            if_done_r   <= 1'b0;
            mem_done_r  <= 1'b0;
            bus_err_r   <= 1'b0;
            if_rdata_r  <= ZeroWord;
            mem_rdata_r <= ZeroWord;
        end else begin
            txn_r       <= txn_s;
            bus_req_r   <= bus_req_s;
            if_done_r   <= if_done_s;
            mem_done_r  <= mem_done_s;
            bus_err_r   <= bus_err_s;
            if_rdata_r  <= if_rdata_s;
            mem_rdata_r <= mem_rdata_s;
        end
    end

    assign bus_req_o   = bus_req_r;
    assign bus_we_o    = txn_r.we;
    assign bus_sel_o   = txn_r.sel;
    assign bus_addr_o  = txn_r.addr;
    assign bus_wdata_o = txn_r.wdata;
    assign if_done_o   = if_done_r;
    assign mem_done_o  = mem_done_r;
    assign if_rdata_o  = if_rdata_r;
    assign mem_rdata_o = mem_rdata_r;
    assign bus_err_o   = bus_err_r;

    // Stall while a request is pending and not completing this cycle.
    assign stallreq_o = (mem_req_i & ~mem_done_r) | (if_req_i & ~if_done_r);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a cycle-numbered
// transaction model.
module tb_mem_bus_arbiter;

    localparam int unsigned TO = 32'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_done_o;
    logic [31:0] if_rdata_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic        mem_done_o;
    logic [31:0] mem_rdata_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        bus_err_o;
    logic        stallreq_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(32'd8)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i),
        .if_done_o(if_done_o), .if_rdata_o(if_rdata_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .mem_done_o(mem_done_o), .mem_rdata_o(mem_rdata_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
        .bus_err_o(bus_err_o), .stallreq_o(stallreq_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // Transactions are tracked by cycle number: 'start' is the first cycle the
    // bus request is visible, 'idle_from' the first cycle a request may win.
    int          cyc = 0;
    int          owner = 0;      // 0 none, 1 fetch, 2 data
    int          start = 0;
    int          idle_from = 0;
    bit          armed = 1'b0;
    logic        m_we = 1'b0;
    logic [3:0]  m_sel = 4'h0;
    logic [31:0] m_addr = 32'h0;
    logic [31:0] m_wdata = 32'h0;
    logic        e_bus_req = 1'b0;
    logic        e_if_done = 1'b0;
    logic        e_mem_done = 1'b0;
    logic        e_err = 1'b0;
    logic [31:0] e_if_rdata = 32'h0;
    logic [31:0] e_mem_rdata = 32'h0;

    task automatic finish_txn(input bit ok, input logic [31:0] data);
        if (owner == 1) begin
            e_if_done  = 1'b1;
            e_if_rdata = ok ? data : 32'h0;
        end else begin
            e_mem_done = 1'b1;
            if (!ok) e_mem_rdata = 32'h0;
            else if (!m_we) e_mem_rdata = data;
        end
        e_err     = !ok;
        owner     = 0;
        idle_from = cyc + 2;
    endtask

    task automatic model_step();
        e_if_done  = 1'b0;
        e_mem_done = 1'b0;
        e_err      = 1'b0;
        if (rst) begin
            owner       = 0;
            idle_from   = cyc + 1;
            e_if_rdata  = 32'h0;
            e_mem_rdata = 32'h0;
            m_we = 1'b0; m_sel = 4'h0; m_addr = 32'h0; m_wdata = 32'h0;
        end else if (owner != 0) begin
            if (bus_ack_i) finish_txn(1'b1, bus_rdata_i);
            else if (TO != 0 && (cyc - start) == int'(TO)) finish_txn(1'b0, 32'h0);
        end else if (cyc >= idle_from) begin
            if (mem_req_i) begin
                owner = 2; start = cyc + 1;
                m_we = mem_we_i; m_sel = mem_sel_i; m_addr = mem_addr_i; m_wdata = mem_wdata_i;
            end else if (if_req_i) begin
                owner = 1; start = cyc + 1;
                m_we = 1'b0; m_sel = 4'hF; m_addr = if_addr_i;
            end
        end
        e_bus_req = (owner != 0);
        cyc++;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            armed = 1'b1;
        end
    end

    // Compare process: every cycle, mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                chk("bus_req", bus_req_o, e_bus_req);
                chk("if_done", if_done_o, e_if_done);
                chk("mem_done", mem_done_o, e_mem_done);
                chk("bus_err", bus_err_o, e_err);
                chk("if_rdata", if_rdata_o, e_if_rdata);
                chk("mem_rdata", mem_rdata_o, e_mem_rdata);
                chk("stallreq", stallreq_o, (mem_req_i & ~e_mem_done) | (if_req_i & ~e_if_done));
                if (e_bus_req) begin
                    chk("bus_we", bus_we_o, m_we);
                    chk("bus_sel", bus_sel_o, m_sel);
                    chk("bus_addr", bus_addr_o, m_addr);
                    if (owner == 2) chk("bus_wdata", bus_wdata_o, m_wdata);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int pct;
        rst = 1'b1; if_req_i = 1'b0; if_addr_i = 32'h0;
        mem_req_i = 1'b0; mem_we_i = 1'b0; mem_sel_i = 4'h0; mem_addr_i = 32'h0; mem_wdata_i = 32'h0;
        bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
        tick(); tick();
        @(negedge clk);
        chk("rst_bus_req", bus_req_o, 1'b0);
        chk("rst_mem_rdata", mem_rdata_o, 32'h0);
        chk("rst_bus_addr", bus_addr_o, 32'h0);
        tick(); rst = 1'b0;
        tick();

        // Fetch only, ack on the second bus cycle.
        tick(); if_req_i = 1'b1; if_addr_i = 32'h0000_0040;
        @(negedge clk); chk("f_stall0", stallreq_o, 1'b1);
        tick(); @(negedge clk);
        chk("f_busreq1", bus_req_o, 1'b1); chk("f_addr", bus_addr_o, 32'h40); chk("f_we", bus_we_o, 1'b0);
        tick(); bus_ack_i = 1'b1; bus_rdata_i = 32'h2402_0005;
        @(negedge clk); chk("f_stall2", stallreq_o, 1'b1); chk("f_done2", if_done_o, 1'b0);
        tick(); bus_ack_i = 1'b0; bus_rdata_i = 32'h5555_5555;
        @(negedge clk); chk("f_done3", if_done_o, 1'b1); chk("f_rdata", if_rdata_o, 32'h2402_0005);
        chk("f_stall3", stallreq_o, 1'b0); chk("f_busreq3", bus_req_o, 1'b0);
        if_req_i = 1'b0;
        tick(); @(negedge clk); chk("f_done4", if_done_o, 1'b0);
        tick();

        // Simultaneous requests, zero-wait ack held high (also spurious acks).
        tick();
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h1000_0000;
        if_req_i = 1'b1; if_addr_i = 32'h0000_0080; bus_ack_i = 1'b1; bus_rdata_i = 32'h1111_2222;
        tick(); @(negedge clk); chk("s_addr1", bus_addr_o, 32'h1000_0000);
        tick(); mem_req_i = 1'b0;
        @(negedge clk); chk("s_mdone2", mem_done_o, 1'b1); chk("s_mrdata", mem_rdata_o, 32'h1111_2222);
        chk("s_idone2", if_done_o, 1'b0);
        tick(); bus_rdata_i = 32'h3333_4444;
        @(negedge clk); chk("s_busreq3", bus_req_o, 1'b0);
        tick(); @(negedge clk); chk("s_busreq4", bus_req_o, 1'b1); chk("s_addr4", bus_addr_o, 32'h80);
        chk("s_sel4", bus_sel_o, 4'hF);
        tick(); if_req_i = 1'b0;
        @(negedge clk); chk("s_idone5", if_done_o, 1'b1); chk("s_irdata", if_rdata_o, 32'h3333_4444);
        tick(); @(negedge clk); chk("s_idone6", if_done_o, 1'b0);
        tick(); @(negedge clk); chk("s_mdone7", mem_done_o, 1'b0);
        bus_ack_i = 1'b0;
        tick();

        // Data write, ack on second bus cycle: read data unchanged.
        tick(); mem_req_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'b0011;
        mem_addr_i = 32'h2000_0010; mem_wdata_i = 32'hDEAD_BEEF; bus_rdata_i = 32'h7777_7777;
        for (int i = 1; i <= 2; i++) begin
            tick(); @(negedge clk);
            chk("w_we", bus_we_o, 1'b1); chk("w_sel", bus_sel_o, 4'b0011); chk("w_wdata", bus_wdata_o, 32'hDEAD_BEEF);
            if (i == 2) bus_ack_i = 1'b1;
        end
        tick(); bus_ack_i = 1'b0; mem_req_i = 1'b0;
        @(negedge clk); chk("w_done", mem_done_o, 1'b1); chk("w_rdata", mem_rdata_o, 32'h1111_2222);
        tick(); @(negedge clk); chk("w_done1", mem_done_o, 1'b0);
        tick();

        // Timeout: no ack at all.
        tick(); mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h3000_0000;
        for (int i = 1; i <= 5; i++) begin
            tick(); @(negedge clk); chk("t_busreq", bus_req_o, 1'b1);
        end
        tick(); mem_req_i = 1'b0;
        @(negedge clk); chk("t_busreq6", bus_req_o, 1'b0); chk("t_done", mem_done_o, 1'b1);
        chk("t_err", bus_err_o, 1'b1); chk("t_rdata", mem_rdata_o, 32'h0);
        tick(); @(negedge clk); chk("t_err7", bus_err_o, 1'b0);
        tick();

        // Ack on the fifth bus cycle wins over the timeout.
        tick(); mem_req_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick(); @(negedge clk); chk("a_busreq", bus_req_o, 1'b1);
        end
        tick(); bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFE_F00D;
        @(negedge clk); chk("a_busreq5", bus_req_o, 1'b1);
        tick(); bus_ack_i = 1'b0; mem_req_i = 1'b0;
        @(negedge clk); chk("a_done", mem_done_o, 1'b1); chk("a_err", bus_err_o, 1'b0);
        chk("a_rdata", mem_rdata_o, 32'hCAFE_F00D);
        tick(); tick();

        // Reset mid-transaction, then a fresh fetch.
        tick(); mem_req_i = 1'b1; mem_addr_i = 32'h0000_0050;
        tick(); tick(); rst = 1'b1; mem_req_i = 1'b0;
        tick(); rst = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h0000_0044; bus_ack_i = 1'b1; bus_rdata_i = 32'h0BAD_F00D;
        @(negedge clk); chk("r_busreq", bus_req_o, 1'b0); chk("r_done", mem_done_o, 1'b0);
        tick(); @(negedge clk); chk("r_addr", bus_addr_o, 32'h44); chk("r_done1", mem_done_o, 1'b0);
        tick(); if_req_i = 1'b0;
        @(negedge clk); chk("r_idone", if_done_o, 1'b1); chk("r_irdata", if_rdata_o, 32'h0BAD_F00D);
        tick(); bus_ack_i = 1'b0;
        tick();

        // Randomized traffic with random acks, reads/writes and resets.
        for (int k = 0; k < 3000; k++) begin
            tick();
            rst = ($urandom_range(0, 149) == 0);
            if (mem_req_i) begin
                if (e_mem_done) mem_req_i = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                mem_req_i   = 1'b1;
                mem_we_i    = 1'($urandom_range(0, 1));
                mem_sel_i   = 4'($urandom);
                mem_addr_i  = $urandom;
                mem_wdata_i = $urandom;
            end
            if (if_req_i) begin
                if (e_if_done) if_req_i = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                if_req_i  = 1'b1;
                if_addr_i = $urandom;
            end
            case ((k / 250) % 4)
                0:       pct = 100;
                1:       pct = 40;
                2:       pct = 10;
                default: pct = 60;
            endcase
            bus_ack_i   = ($urandom_range(0, 99) < pct);
            bus_rdata_i = $urandom;
        end
        tick(); rst = 1'b0; mem_req_i = 1'b0; if_req_i = 1'b0; bus_ack_i = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
